// File: rtl/shift_pkg.sv
// Shared constants for the multi-cycle EX-stage shifter: op encodings,
// controller states and default widths.
package shift_pkg;

    localparam int XLEN_DEF = 32;
    localparam int STEP_DEF = 4;

    // bit0 selects right shift, bit1 selects arithmetic fill
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves the word by 0..STEP positions,
// filling right shifts with the supplied fill bit.
module shift_step #(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] data,
    input  logic [KW-1:0]   k,
    input  logic            right,
    input  logic            fill,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] fill_mask;

    // Vacated upper positions of a right shift become ones for a negative SRA operand
    always_comb begin
        fill_mask = fill ? ~({XLEN{1'b1}} >> k) : '0;
        if (right) begin
            result = (data >> k) | fill_mask;
        end else begin
            result = data << k;
        end
    end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shift unit: accepts an operand on a valid/ready handshake,
// shifts at most STEP positions per clock and returns the result on a second handshake.
module serial_shifter
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int STEP = STEP_DEF,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_data,
    input  logic [SHW-1:0]  in_shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    localparam int KW = $clog2(STEP + 1);
    localparam logic [SHW:0] STEP_LIM = STEP[SHW:0];

    state_t          state;
    state_t          state_next;
    logic [SHW-1:0]  rem;
    logic [SHW-1:0]  rem_after;
    logic [SHW:0]    k_wide;
    logic [XLEN-1:0] work;
    logic [XLEN-1:0] step_out;
    logic            right;
    logic            fill;

    // Distance moved this cycle is min(rem, STEP)
    always_comb begin
        k_wide    = ({1'b0, rem} < STEP_LIM) ? {1'b0, rem} : STEP_LIM;
        rem_after = rem - k_wide[SHW-1:0];
    end

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP),
        .KW   (KW)
    ) u_step (
        .data   (work),
        .k      (k_wide[KW-1:0]),
        .right  (right),
        .fill   (fill),
        .result (step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides both handshakes, so it is applied last
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (in_shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_after == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // The SRA fill bit is captured at accept time since the MSB shifts away
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work  <= '0;
            rem   <= '0;
            right <= 1'b0;
            fill  <= 1'b0;
        end else if (!flush) begin
            if (state == IDLE && in_valid) begin
                work  <= in_data;
                rem   <= in_shamt;
                right <= in_op[0];
                fill  <= (in_op == OP_SRA) && in_data[XLEN-1];
            end else if (state == SHIFT) begin
                work <= step_out;
                rem  <= rem_after;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter with a result scoreboard
// (expected data and latency pushed at accept, popped at delivery).
module tb_serial_shifter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_data_q[$];
    int          exp_lat_q[$];

    always #5 clk = ~clk;

    serial_shifter dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [31:0] d,
                                                input logic [4:0] sh);
        logic signed [31:0] s;
        s = d;
        if (op == OP_SRL) return d >> sh;
        if (op == OP_SRA) return s >>> sh;
        return d << sh;
    endfunction

    // Drives one request, waits (bounded) for acceptance and records the expectation
    task automatic send_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        int n;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_data_q.push_back(model_shift(op, d, sh));
        exp_lat_q.push_back(1 + (int'(sh) + 3) / 4);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_data = '0; in_shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (out_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ops();
        logic [1:0]  ops[12];
        logic [31:0] ds[12];
        logic [4:0]  shs[12];
        logic [31:0] ed;
        int          el;
        int          lat;
        ops[0] = OP_SLL; ds[0] = 32'h0000_0001; shs[0] = 5'd31;
        ops[1] = OP_SRA; ds[1] = 32'h8000_0000; shs[1] = 5'd4;
        ops[2] = OP_SRA; ds[2] = 32'h7FFF_FFF0; shs[2] = 5'd4;
        ops[3] = OP_SRL; ds[3] = 32'hF000_000F; shs[3] = 5'd0;
        ops[4] = OP_SRL; ds[4] = 32'h8000_0000; shs[4] = 5'd31;
        ops[5] = 2'b10;  ds[5] = 32'h0000_0001; shs[5] = 5'd3;
        ops[6] = OP_SRA; ds[6] = 32'h8765_4321; shs[6] = 5'd17;
        ops[7] = OP_SRL; ds[7] = 32'hDEAD_BEEF; shs[7] = 5'd13;
        for (int i = 8; i < 12; i++) begin
            ops[i] = 2'($urandom_range(0, 3));
            ds[i]  = $urandom;
            shs[i] = 5'($urandom_range(0, 31));
        end
        for (int i = 0; i < 12; i++) begin
            send_op(ops[i], ds[i], shs[i]);
            lat = 1;
            while (!out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            ed = exp_data_q.pop_front();
            el = exp_lat_q.pop_front();
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL op%0d_timeout: out_valid=%b required 1", i, out_valid);
            end
            vectors++;
            if (out_data !== ed) begin
                miscompares++;
                $display("[TB] FAIL op%0d_data: got %h want %h", i, out_data, ed);
            end
            vectors++;
            if (lat != el) begin
                miscompares++;
                $display("[TB] FAIL op%0d_latency: got %0d want %0d", i, lat, el);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL op%0d_release: in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed;
        int          n;
        send_op(OP_SLL, 32'h0000_0003, 5'd2);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        ed = exp_data_q.pop_front();
        void'(exp_lat_q.pop_front());
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_op    = OP_SRL;
            in_data  = 32'hFFFF_FFFF;
            in_shamt = 5'd1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ed) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d: valid=%b ready=%b data=%h want 1/0/%h",
                         c, out_valid, in_ready, out_data, ed);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release: in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_no_accept: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
    endtask

    task automatic test_flush_shift();
        int seen;
        send_op(OP_SLL, 32'h0000_0001, 5'd20);
        void'(exp_data_q.pop_front());
        void'(exp_lat_q.pop_front());
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_shift_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("[TB] FAIL flush_shift_no_result: out_valid cycles=%0d want 0", seen);
        end
        // flush together with in_valid in IDLE must not accept
        in_op = OP_SLL; in_data = 32'h1; in_shamt = 5'd0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_idle_accept: busy=%b out_valid=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_flush_done();
        int seen;
        send_op(OP_SRL, 32'h1234_5678, 5'd0);
        void'(exp_data_q.pop_front());
        void'(exp_lat_q.pop_front());
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_done_valid: out_valid=%b want 1", out_valid);
        end
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("[TB] FAIL flush_done_second: bad cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] ed;
        int          el;
        int          lat;
        send_op(OP_SLL, 32'h0000_0001, 5'd20);
        void'(exp_data_q.pop_front());
        void'(exp_lat_q.pop_front());
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL async_reset: valid=%b data=%h ready=%b want 0/0/1", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        send_op(OP_SRA, 32'hFFFF_FF00, 5'd8);
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        ed = exp_data_q.pop_front();
        el = exp_lat_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== ed || lat != el) begin
            miscompares++;
            $display("[TB] FAIL post_reset_sra: valid=%b data=%h lat=%0d want 1/%h/%0d",
                     out_valid, out_data, lat, ed, el);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_flush_shift();
        test_flush_done();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_shifter.md
# serial_shifter

Multi-cycle shift unit for the EX stage of the 5-stage pipeline. It performs logical left, logical right and arithmetic right shifts of a 32-bit operand, moving at most STEP bit positions per clock. Operands come in on a valid/ready handshake, the result leaves on a second valid/ready handshake, and a pipeline flush aborts the operation in flight. The right-shift paths complement the fixed left-shift helpers already used for address and offset scaling.

## Interface
- XLEN, 32, operand/result width; must be a power of two
- STEP, 4, maximum shift distance per cycle; legal range 1..XLEN
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; polarity and synchronicity fixed
- flush  in  1  synchronous abort from the hazard unit
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept an operand
- in_op  in  2  bit0 = right, bit1 = arithmetic; 00 SLL, 01 SRL, 11 SRA, 10 treated as SLL
- in_data  in  XLEN  operand
- in_shamt  in  SHW  shift amount; upper bits of any wider source are dropped by the caller
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_data  out  XLEN  shifted result
- busy  out  1  high in SHIFT or DONE

## Operation
- States:
  - IDLE: in_ready = 1.
  - SHIFT: working register and remaining count rem are updated each cycle.
  - DONE: out_valid = 1.
- IDLE to next state: on in_valid && in_ready, latch in_data, in_op and rem = in_shamt.
  - Go to DONE if in_shamt == 0, otherwise to SHIFT.
- SHIFT, each edge:
  - Shift the working register by k = min(rem, STEP), then rem -= k.
  - Go to DONE when the new rem is 0.
- Shift fill rules:
  - Left shifts fill with zeros.
  - SRL fills with zeros.
  - SRA fills with the operand's bit XLEN-1, latched at accept time.
- DONE: hold out_data stable. On out_valid && out_ready, go to IDLE.
- flush: from any state, go to IDLE on the next edge. Flush has priority over both handshakes; no result is delivered.
- reset (asynchronous) values:
  - state = IDLE, rem = 0, working register = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
- The working register is only XLEN bits wide. out_data is the working register.

## Timing
- Latency from the accept edge to out_valid high is 1 + ceil(in_shamt / STEP) cycles; minimum 1 (shamt = 0), maximum 1 + ceil((XLEN-1)/STEP).
- in_ready, out_valid and busy are decoded from registered state only; none depends combinationally on an input.
- There is no same-cycle turnaround: after the output handshake, in_ready rises in the following cycle. Throughput is one operation per latency + 1 cycles.
- Simultaneous in_valid and flush in IDLE: the operand is not accepted.
- Simultaneous out_ready and flush in DONE: treated as a flush. The consumer must qualify out_ready against flush.
- in_valid while in SHIFT or DONE is ignored; the caller holds the request until in_ready.
- Reset asserted mid-SHIFT: outputs take their reset values immediately. After release, the unit restarts in IDLE.

## Structure
- shift_pkg holds:
  - op encodings OP_SLL, OP_SRL, OP_SRA
  - state enum IDLE/SHIFT/DONE
  - default XLEN and STEP constants
- Sub-module shift_step: purely combinational.
  - Inputs: data, distance k (0..STEP), direction, fill bit. Output: the shifted word.
  - Instantiated once by serial_shifter.
- All state, rem and handshake logic live in serial_shifter.

## Test plan
- SLL 0x0000_0001 by 31, STEP = 4 -> out_data 0x8000_0000, out_valid 9 cycles after accept.
- SRA 0x8000_0000 by 4 -> 0xF800_0000 at latency 2. SRA 0x7FFF_FFF0 by 4 -> 0x07FF_FFFF.
- SRL 0xF000_000F by 0 -> 0xF000_000F at latency 1. SRL 0x8000_0000 by 31 -> 0x0000_0001. Op 2'b10 on 0x1 by 3 -> 0x8.
- Backpressure:
  - Stimulus: out_ready held low for 5 cycles in DONE while in_valid is pulsed with a new operand.
  - Required: out_data stable, in_ready = 0, new operand never accepted.
  - Then out_ready = 1 -> in_ready = 1 the next cycle.
- flush during SHIFT (SLL by 20) -> out_valid never rises, in_ready = 1 on the cycle after flush. flush and out_ready together in DONE -> no second result.
- Asynchronous reset mid-SHIFT -> out_valid = 0, out_data = 0, in_ready = 1 before the next clock edge. A following SRA 0xFFFF_FF00 by 8 -> 0xFFFF_FFFF.
